// File: rtl/scfifo_pkg.sv
// Shared types and sizing helpers for the single-clock FIFO controller and its output buffer.
package scfifo_pkg;

    localparam int BUF_DEPTH        = 2;
    localparam int DEFAULT_RAM_SIZE = 12;

    // Room for RAM_SIZE words in the RAM plus one in flight and two buffered.
    function automatic int cnt_width(input int ram_size);
        return $clog2(ram_size + 3);
    endfunction

    typedef logic [1:0]                                buf_cnt_t;
    typedef logic [cnt_width(DEFAULT_RAM_SIZE)-1:0]    occ_cnt_t;

endpackage

// File: rtl/scfifo_obuf.sv
// Two-entry output skid buffer: head register drives the stream, skid register absorbs
// the word still arriving from the RAM while the head is stalled.
module scfifo_obuf
    import scfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] head,
    output buf_cnt_t              count
);

    logic [DATA_WIDTH-1:0] skid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head  <= '0;
            skid  <= '0;
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        head <= din;
                    else
                        skid <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= skid;
                    count <= count - 2'd1;
                end
                // Simultaneous push/pop keeps the count; a full buffer shifts skid forward.
                2'b11: begin
                    if (count == 2'd2) begin
                        head <= skid;
                        skid <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/scfifo_ctrl.sv
// Controller turning mpmp_ram into a valid/ready FIFO; hides the RAM read latency with scfifo_obuf.
// Optional almost-full/almost-empty flags are enabled by defining SCFIFO_CTRL_ALMOST_FLAGS_EN.
module scfifo_ctrl
    import scfifo_pkg::*;
#(
    parameter int DATA_WIDTH = 10,
    parameter int RAM_SIZE   = 12,
    parameter int CNT_WIDTH  = cnt_width(RAM_SIZE)
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
    ,
    parameter int AFULL_LVL  = RAM_SIZE - 2,
    parameter int AEMPTY_LVL = 2
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  ram_write,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    output logic                  ram_read,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic [CNT_WIDTH-1:0]  usedw,
    output logic                  empty,
    output logic                  full
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
    ,
    output logic                  almost_full,
    output logic                  almost_empty
`endif
);

    logic [CNT_WIDTH-1:0] ram_cnt;
    logic [CNT_WIDTH-1:0] ram_cnt_nxt;
    logic                 inflight;
    buf_cnt_t             buf_cnt;
    logic                 m_fire;
    logic [2:0]           window;

    assign s_ready   = ram_cnt < CNT_WIDTH'(RAM_SIZE);
    assign ram_write = s_valid & s_ready;
    assign ram_wdata = s_data;

    assign m_valid = (buf_cnt != 2'd0);
    assign m_fire  = m_valid & m_ready;

    // Words already committed to the output side; prefetch only while it stays within two.
    assign window   = {1'b0, buf_cnt} + {2'b00, inflight};
    assign ram_read = (ram_cnt != '0) && (window < (3'(BUF_DEPTH) + {2'b00, m_fire}));

    assign ram_cnt_nxt = ram_cnt + CNT_WIDTH'(ram_write) - CNT_WIDTH'(ram_read);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_cnt  <= '0;
            inflight <= 1'b0;
        end else begin
            ram_cnt  <= ram_cnt_nxt;
            inflight <= ram_read;
        end
    end

    scfifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight),
        .pop     (m_fire),
        .din     (ram_rdata),
        .head    (m_data),
        .count   (buf_cnt)
    );

    assign usedw = ram_cnt + CNT_WIDTH'(inflight) + CNT_WIDTH'(buf_cnt);
    assign empty = (usedw == '0);
    assign full  = !s_ready;

`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
    logic [2:0]           buf_cnt_nxt;
    logic [CNT_WIDTH-1:0] usedw_nxt;

    // Flags are registered from the post-edge occupancy so they line up with usedw.
    assign buf_cnt_nxt = window - {2'b00, m_fire};
    assign usedw_nxt   = ram_cnt_nxt + CNT_WIDTH'(ram_read) + CNT_WIDTH'(buf_cnt_nxt);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (usedw_nxt >= CNT_WIDTH'(AFULL_LVL));
            almost_empty <= (usedw_nxt <= CNT_WIDTH'(AEMPTY_LVL));
        end
    end
`endif

endmodule

// File: tb/tb_scfifo_ctrl.sv
// Self-checking bench for scfifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_scfifo_ctrl;

    localparam int DW = 10;
    localparam int RS = 12;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          ram_write;
    logic [DW-1:0] ram_wdata;
    logic          ram_read;
    logic [DW-1:0] ram_rdata;
    logic [CW-1:0] usedw;
    logic          empty;
    logic          full;
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
    logic          almost_full;
    logic          almost_empty;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    scfifo_ctrl #(
        .DATA_WIDTH (DW),
        .RAM_SIZE   (RS),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .ram_write    (ram_write),
        .ram_wdata    (ram_wdata),
        .ram_read     (ram_read),
        .ram_rdata    (ram_rdata),
        .usedw        (usedw),
        .empty        (empty),
        .full         (full)
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    // Pointer RAM with one-cycle read latency, sharing the FIFO reset.
    logic [DW-1:0] mem [RS];
    int            wptr;
    int            rptr;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr      <= 0;
            rptr      <= 0;
            ram_rdata <= '0;
        end else begin
            if (ram_write) begin
                mem[wptr] <= ram_wdata;
                wptr      <= (wptr + 1) % RS;
            end
            if (ram_read) begin
                ram_rdata <= mem[rptr];
                rptr      <= (rptr + 1) % RS;
            end
        end
    end

    // FIFO model: all held words in order, the front 'vis' are presented,
    // 'pend' more are on their way out, the rest sit in the RAM.
    logic [DW-1:0] mq[$];
    int            vis  = 0;
    int            pend = 0;
    bit            mf, mw, mr;

    function automatic int stored();
        return mq.size() - vis - pend;
    endfunction

    function automatic bit exp_sready();
        return stored() < RS;
    endfunction

    function automatic bit exp_fire();
        return (vis > 0) && m_ready;
    endfunction

    function automatic bit exp_write();
        return s_valid && exp_sready();
    endfunction

    function automatic bit exp_read();
        return (stored() > 0) && ((vis + pend - int'(exp_fire())) < 2);
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            vis  = 0;
            pend = 0;
        end else begin
            mf = exp_fire();
            mw = exp_write();
            mr = exp_read();
            if (mf) begin
                void'(mq.pop_front());
                vis--;
            end
            vis  += pend;
            pend  = int'(mr);
            if (mw)
                mq.push_back(s_data);
        end
    end

    logic [DW-1:0] recv[$];

    always @(posedge clk) begin
        if (reset_n && m_valid && m_ready)
            recv.push_back(m_data);
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit sv, input logic [DW-1:0] sd, input bit mr_in);
        s_valid = sv;
        s_data  = sd;
        m_ready = mr_in;
        @(posedge clk);
        #1;
    endtask

    // Every cycle out of reset the DUT must agree with the model.
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("usedw", int'(usedw), mq.size());
            checkOutput("m_valid", int'(m_valid), int'(vis > 0));
            if (vis > 0)
                checkOutput("m_data", int'(m_data), int'(mq[0]));
            checkOutput("s_ready", int'(s_ready), int'(exp_sready()));
            checkOutput("full", int'(full), int'(!exp_sready()));
            checkOutput("empty", int'(empty), int'(mq.size() == 0));
            checkOutput("ram_write", int'(ram_write), int'(exp_write()));
            checkOutput("ram_read", int'(ram_read), int'(exp_read()));
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
            checkOutput("almost_full", int'(almost_full), int'(mq.size() >= RS - 2));
            checkOutput("almost_empty", int'(almost_empty), int'(mq.size() <= 2));
`endif
        end
    end

    logic [DW-1:0] expq[$];
    int            bubbles;
    int            idx;
    bit            acc;
    bit            rdy;

    initial begin
        #12;
        checkOutput("rst_usedw", int'(usedw), 0);
        checkOutput("rst_m_valid", int'(m_valid), 0);
        checkOutput("rst_m_data", int'(m_data), 0);
        checkOutput("rst_empty", int'(empty), 1);
        checkOutput("rst_full", int'(full), 0);
        checkOutput("rst_s_ready", int'(s_ready), 1);
`ifdef SCFIFO_CTRL_ALMOST_FLAGS_EN
        checkOutput("rst_almost_full", int'(almost_full), 0);
        checkOutput("rst_almost_empty", int'(almost_empty), 1);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(0, '0, 0);

        // Single word through an empty FIFO.
        applyStimulus(1, 10'h155, 1);
        checkOutput("single_usedw_e0", int'(usedw), 1);
        checkOutput("single_valid_e0", int'(m_valid), 0);
        applyStimulus(0, '0, 1);
        checkOutput("single_valid_e1", int'(m_valid), 0);
        applyStimulus(0, '0, 1);
        checkOutput("single_valid_e2", int'(m_valid), 1);
        checkOutput("single_data_e2", int'(m_data), 'h155);
        applyStimulus(0, '0, 1);
        checkOutput("single_usedw_pop", int'(usedw), 0);
        checkOutput("single_empty_pop", int'(empty), 1);
        repeat (2) applyStimulus(0, '0, 0);

        // Fill to capacity with the sink stalled, then probe writes and pops at the limit.
        recv.delete();
        expq.delete();
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1, 10'(12'h100 + i), 0);
            expq.push_back(10'(12'h100 + i));
        end
        checkOutput("fill_usedw", int'(usedw), 14);
        checkOutput("fill_s_ready", int'(s_ready), 0);
        checkOutput("fill_full", int'(full), 1);
        applyStimulus(1, 10'h3FF, 0);
        checkOutput("fill_ignored_usedw", int'(usedw), 14);
        checkOutput("fill_head", int'(m_data), 'h100);
        applyStimulus(0, '0, 1);
        checkOutput("pop_usedw", int'(usedw), 13);
        checkOutput("pop_s_ready", int'(s_ready), 1);
        applyStimulus(1, 10'h20E, 1);
        expq.push_back(10'h20E);
        checkOutput("wrpop_usedw", int'(usedw), 13);
        checkOutput("wrpop_head", int'(m_data), 'h102);
        applyStimulus(1, 10'h20F, 0);
        expq.push_back(10'h20F);
        checkOutput("refill_usedw", int'(usedw), 14);
        checkOutput("refill_full", int'(full), 1);
        for (int c = 0; c < 100 && usedw != 0; c++)
            applyStimulus(0, '0, 1);
        checkOutput("fill_recv_count", recv.size(), 16);
        for (int i = 0; i < recv.size() && i < 16; i++)
            checkOutput("fill_order", int'(recv[i]), int'(expq[i]));
        repeat (2) applyStimulus(0, '0, 0);

        // Streaming: one word per cycle with no bubbles once the pipe is primed.
        recv.delete();
        bubbles = 0;
        for (int k = 0; k < 106; k++) begin
            if (k >= 3 && k <= 102 && !m_valid)
                bubbles++;
            applyStimulus(k < 100, 10'(k), 1);
        end
        checkOutput("stream_bubbles", bubbles, 0);
        checkOutput("stream_count", recv.size(), 100);
        for (int i = 0; i < recv.size() && i < 100; i++)
            checkOutput("stream_order", int'(recv[i]), i);
        checkOutput("stream_usedw_end", int'(usedw), 0);

        // Random backpressure across several RAM wraps.
        recv.delete();
        idx = 0;
        for (int c = 0; c < 2000 && recv.size() < 40; c++) begin
            rdy = ($urandom_range(0, 9) < 3);
            acc = (idx < 40) && s_ready;
            applyStimulus(idx < 40, 10'(idx * 7 + 3), rdy);
            if (acc)
                idx++;
        end
        checkOutput("bp_count", recv.size(), 40);
        for (int i = 0; i < recv.size() && i < 40; i++)
            checkOutput("bp_order", int'(recv[i]), (i * 7 + 3) % 1024);
        repeat (3) applyStimulus(0, '0, 1);

        // Reset in the middle of a partially filled FIFO.
        for (int i = 0; i < 7; i++)
            applyStimulus(1, 10'(12'h050 + i), 0);
        checkOutput("mid_usedw", int'(usedw), 7);
        s_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_usedw", int'(usedw), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkOutput("post_rst_usedw", int'(usedw), 0);
        checkOutput("post_rst_m_valid", int'(m_valid), 0);
        checkOutput("post_rst_s_ready", int'(s_ready), 1);
        applyStimulus(1, 10'h2AA, 1);
        applyStimulus(0, '0, 1);
        applyStimulus(0, '0, 1);
        checkOutput("post_rst_valid", int'(m_valid), 1);
        checkOutput("post_rst_data", int'(m_data), 'h2AA);
        applyStimulus(0, '0, 1);
        checkOutput("post_rst_drain", int'(usedw), 0);
        applyStimulus(0, '0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
